// File: rtl/fanin_req_arb_bridge_if.sv
// fanin_req_arb_bridge_if: upstream request fan-in bus plus registered downstream request port
interface fanin_req_arb_bridge_if #(
    parameter int N_CH       = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH/8,
    parameter int ID_WIDTH   = 16,
    parameter int AUX_WIDTH  = 32,
    parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic [N_CH-1:0]            data_req_i;
    logic [N_CH*DATA_WIDTH-1:0] data_wdata_i;
    logic [N_CH*ADDR_WIDTH-1:0] data_add_i;
    logic [N_CH-1:0]            data_wen_i;
    logic [N_CH*BE_WIDTH-1:0]   data_be_i;
    logic [N_CH*ID_WIDTH-1:0]   data_ID_i;
    logic [N_CH*AUX_WIDTH-1:0]  data_aux_i;
    logic [N_CH-1:0]            data_gnt_o;
    logic                       data_req_o;
    logic [DATA_WIDTH-1:0]      data_wdata_o;
    logic [ADDR_WIDTH-1:0]      data_add_o;
    logic                       data_wen_o;
    logic [BE_WIDTH-1:0]        data_be_o;
    logic [ID_WIDTH-1:0]        data_ID_o;
    logic [AUX_WIDTH-1:0]       data_aux_o;
    logic [CH_W-1:0]            data_src_o;
    logic                       data_gnt_i;

    modport slave (
        input  data_req_i, data_wdata_i, data_add_i, data_wen_i, data_be_i, data_ID_i, data_aux_i, data_gnt_i,
        output data_gnt_o, data_req_o, data_wdata_o, data_add_o, data_wen_o, data_be_o, data_ID_o, data_aux_o, data_src_o
    );
    modport master (
        output data_req_i, data_wdata_i, data_add_i, data_wen_i, data_be_i, data_ID_i, data_aux_i, data_gnt_i,
        input  data_gnt_o, data_req_o, data_wdata_o, data_add_o, data_wen_o, data_be_o, data_ID_o, data_aux_o, data_src_o
    );
endinterface

// File: rtl/fanin_req_arb_bridge.sv
// fanin_req_arb_bridge: round-robin N-channel request fan-in into a one-entry registered slice
module fanin_req_arb_bridge #(
    parameter int N_CH       = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH/8,
    parameter int ID_WIDTH   = 16,
    parameter int AUX_WIDTH  = 32,
    parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input logic                    clk,
    input logic                    rst,
    fanin_req_arb_bridge_if.slave  bus
);
    logic                  r_valid;
    logic [CH_W-1:0]       r_ptr, r_src;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [ADDR_WIDTH-1:0] r_add;
    logic                  r_wen;
    logic [BE_WIDTH-1:0]   r_be;
    logic [ID_WIDTH-1:0]   r_id;
    logic [AUX_WIDTH-1:0]  r_aux;
    logic [CH_W-1:0]       w_win, w_cand, w_ptr_nxt;
    logic                  w_accept, w_fire;
    logic [N_CH-1:0]       w_gnt;
    logic [DATA_WIDTH-1:0] w_wdata [N_CH];
    logic [ADDR_WIDTH-1:0] w_add   [N_CH];
    logic [BE_WIDTH-1:0]   w_be    [N_CH];
    logic [ID_WIDTH-1:0]   w_id    [N_CH];
    logic [AUX_WIDTH-1:0]  w_aux   [N_CH];

    for (genvar c = 0; c < N_CH; c++) begin : g_unpack
        assign w_wdata[c] = bus.data_wdata_i[c*DATA_WIDTH +: DATA_WIDTH];
        assign w_add[c]   = bus.data_add_i[c*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_be[c]    = bus.data_be_i[c*BE_WIDTH +: BE_WIDTH];
        assign w_id[c]    = bus.data_ID_i[c*ID_WIDTH +: ID_WIDTH];
        assign w_aux[c]   = bus.data_aux_i[c*AUX_WIDTH +: AUX_WIDTH];
    end

    // Scan from the farthest offset down so the channel nearest rr_ptr wins; wrap by modulo.
    always_comb begin
        w_win  = '0;
        w_cand = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            w_cand = CH_W'((int'(r_ptr) + k) % N_CH);
            if (bus.data_req_i[w_cand]) w_win = w_cand;
        end
    end

    assign w_accept  = ~r_valid | bus.data_gnt_i;
    assign w_fire    = ~rst & w_accept & (|bus.data_req_i);
    assign w_ptr_nxt = (w_win == CH_W'(N_CH - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        w_gnt        = '0;
        w_gnt[w_win] = w_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ptr   <= '0;
            r_src   <= '0;
            r_wdata <= '0;
            r_add   <= '0;
            r_wen   <= 1'b0;
            r_be    <= '0;
            r_id    <= '0;
            r_aux   <= '0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_ptr   <= w_ptr_nxt;
            r_src   <= w_win;
            r_wdata <= w_wdata[w_win];
            r_add   <= w_add[w_win];
            r_wen   <= bus.data_wen_i[w_win];
            r_be    <= w_be[w_win];
            r_id    <= w_id[w_win];
            r_aux   <= w_aux[w_win];
        end else if (bus.data_gnt_i) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.data_gnt_o   = w_gnt;
    assign bus.data_req_o   = r_valid;
    assign bus.data_src_o   = r_src;
    assign bus.data_wdata_o = r_wdata;
    assign bus.data_add_o   = r_add;
    assign bus.data_wen_o   = r_wen;
    assign bus.data_be_o    = r_be;
    assign bus.data_ID_o    = r_id;
    assign bus.data_aux_o   = r_aux;
endmodule

// File: tb/tb_fanin_req_arb_bridge.sv
// tb_fanin_req_arb_bridge: vector table, directed corner sequences and randomized model check
module tb_fanin_req_arb_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fanin_req_arb_bridge_if #(.N_CH(4)) bus4 ();
    fanin_req_arb_bridge_if #(.N_CH(3)) bus3 ();

    fanin_req_arb_bridge #(.N_CH(4)) u4 (.clk(clk), .rst(rst), .bus(bus4));
    fanin_req_arb_bridge #(.N_CH(3)) u3 (.clk(clk), .rst(rst), .bus(bus3));

    logic [3:0]  t_req = '0;
    logic [3:0]  t_wen = '0;
    logic [31:0] t_add [4];
    logic [31:0] t_wdata [4];
    logic [31:0] t_aux [4];
    logic [3:0]  t_be [4];
    logic [15:0] t_id [4];

    assign bus4.data_req_i   = t_req;
    assign bus4.data_wen_i   = t_wen;
    assign bus4.data_add_i   = {t_add[3], t_add[2], t_add[1], t_add[0]};
    assign bus4.data_wdata_i = {t_wdata[3], t_wdata[2], t_wdata[1], t_wdata[0]};
    assign bus4.data_aux_i   = {t_aux[3], t_aux[2], t_aux[1], t_aux[0]};
    assign bus4.data_be_i    = {t_be[3], t_be[2], t_be[1], t_be[0]};
    assign bus4.data_ID_i    = {t_id[3], t_id[2], t_id[1], t_id[0]};

    typedef struct packed {
        logic        rst;
        logic [3:0]  req;
        logic        g;
        logic [3:0]  egnt;
        logic        ereq;
        logic [1:0]  esrc;
        logic [31:0] eadd;
    } vec_t;
    vec_t tv [18];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    bit          m_valid;
    int          m_ptr, m_src, w;
    logic [31:0] m_add, m_wdata, m_aux;
    logic        m_wen;
    logic [3:0]  m_be, egnt;
    logic [15:0] m_id;

    initial begin
        tv[0]  = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0, 32'h0};
        tv[1]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 32'h0};
        tv[2]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 32'hA000};
        tv[3]  = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 32'hA010};
        tv[4]  = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd2, 32'hA020};
        tv[5]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd3, 32'hA030};
        tv[6]  = '{1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 2'd0, 32'hA000};
        tv[7]  = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd2, 32'hA020};
        tv[8]  = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd2, 32'hA020};
        tv[9]  = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd2, 32'hA020};
        tv[10] = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd2, 32'hA020};
        tv[11] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd3, 32'hA030};
        tv[12] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd3, 32'hA030};
        tv[13] = '{1'b0, 4'h2, 1'b0, 4'h2, 1'b0, 2'd3, 32'hA030};
        tv[14] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 2'd1, 32'hA010};
        tv[15] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, 32'hA010};
        tv[16] = '{1'b0, 4'hF, 1'b0, 4'h1, 1'b0, 2'd0, 32'h0};
        tv[17] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd0, 32'hA000};

        for (int c = 0; c < 4; c++) begin
            t_add[c]   = 32'hA000 + 32'(c * 16);
            t_wdata[c] = '0;
            t_aux[c]   = '0;
            t_be[c]    = '0;
            t_id[c]    = '0;
        end
        bus3.data_req_i   = '0;
        bus3.data_gnt_i   = 1'b0;
        bus3.data_add_i   = {32'hB002, 32'hB001, 32'hB000};
        bus3.data_wdata_i = '0;
        bus3.data_wen_i   = '0;
        bus3.data_be_i    = '0;
        bus3.data_ID_i    = '0;
        bus3.data_aux_i   = '0;
        rst = 1'b1;
        t_req = 4'hF;
        bus4.data_gnt_i = 1'b0;
        tick();

        for (int i = 0; i < 18; i++) begin
            rst = tv[i].rst;
            t_req = tv[i].req;
            bus4.data_gnt_i = tv[i].g;
            #1;
            chk($sformatf("tbl%0d_gnt", i), 64'(bus4.data_gnt_o), 64'(tv[i].egnt));
            chk($sformatf("tbl%0d_req", i), 64'(bus4.data_req_o), 64'(tv[i].ereq));
            chk($sformatf("tbl%0d_src", i), 64'(bus4.data_src_o), 64'(tv[i].esrc));
            chk($sformatf("tbl%0d_add", i), 64'(bus4.data_add_o), 64'(tv[i].eadd));
            tick();
        end

        // Back-to-back reload from channel 1 (rr_ptr is 1 here)
        for (int i = 0; i < 3; i++) begin
            t_req = 4'h2;
            t_add[1] = 32'h100 + 32'(4 * i);
            bus4.data_gnt_i = 1'b1;
            #1;
            chk($sformatf("b2b%0d_gnt", i), 64'(bus4.data_gnt_o), 64'h2);
            if (i > 0) begin
                chk($sformatf("b2b%0d_req", i), 64'(bus4.data_req_o), 64'h1);
                chk($sformatf("b2b%0d_add", i), 64'(bus4.data_add_o), 64'(32'h100 + 32'(4 * (i - 1))));
            end
            tick();
        end
        t_req = 4'h0;
        #1;
        chk("b2b_last_req", 64'(bus4.data_req_o), 64'h1);
        chk("b2b_last_add", 64'(bus4.data_add_o), 64'h108);
        tick();
        bus4.data_gnt_i = 1'b0;
        #1;
        chk("b2b_drained", 64'(bus4.data_req_o), 64'h0);

        // Explicit wrap on N_CH=3 with rr_ptr=2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus3.data_gnt_i = 1'b1;
        bus3.data_req_i = 3'b001;
        #1;
        chk("w3_gnt0", 64'(bus3.data_gnt_o), 64'h1);
        tick();
        bus3.data_req_i = 3'b010;
        #1;
        chk("w3_gnt1", 64'(bus3.data_gnt_o), 64'h2);
        tick();
        bus3.data_req_i = 3'b011;
        #1;
        chk("w3_wrap_gnt", 64'(bus3.data_gnt_o), 64'h1);
        chk("w3_src1", 64'(bus3.data_src_o), 64'h1);
        chk("w3_add1", 64'(bus3.data_add_o), 64'hB001);
        tick();
        #1;
        chk("w3_ptr1_gnt", 64'(bus3.data_gnt_o), 64'h2);
        chk("w3_src0", 64'(bus3.data_src_o), 64'h0);
        chk("w3_add0", 64'(bus3.data_add_o), 64'hB000);
        tick();
        bus3.data_req_i = 3'b000;
        #1;
        chk("w3_src_last", 64'(bus3.data_src_o), 64'h1);
        tick();

        // Randomized run against a transaction-level model
        t_req = '0;
        m_valid = 1'b0;
        m_ptr = 0;
        m_src = 0;
        for (int n = 0; n < 400; n++) begin
            rst = (n == 0) || ($urandom_range(39) == 0);
            bus4.data_gnt_i = ($urandom_range(9) < 7);
            for (int c = 0; c < 4; c++) begin
                if (!t_req[c] && $urandom_range(1) == 1) begin
                    t_req[c]   = 1'b1;
                    t_add[c]   = $urandom;
                    t_wdata[c] = $urandom;
                    t_aux[c]   = $urandom;
                    t_wen[c]   = 1'($urandom_range(1));
                    t_be[c]    = 4'($urandom);
                    t_id[c]    = 16'($urandom);
                end
            end
            #1;
            w = -1;
            egnt = '0;
            if (!rst && (!m_valid || bus4.data_gnt_i))
                for (int k = 0; k < 4; k++)
                    if (w < 0 && t_req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            if (w >= 0) egnt[w] = 1'b1;
            chk("rnd_gnt",   64'(bus4.data_gnt_o),   64'(egnt));
            chk("rnd_req",   64'(bus4.data_req_o),   64'(m_valid));
            chk("rnd_src",   64'(bus4.data_src_o),   64'(m_src));
            chk("rnd_add",   64'(bus4.data_add_o),   64'(m_add));
            chk("rnd_wdata", 64'(bus4.data_wdata_o), 64'(m_wdata));
            chk("rnd_wen",   64'(bus4.data_wen_o),   64'(m_wen));
            chk("rnd_be",    64'(bus4.data_be_o),    64'(m_be));
            chk("rnd_id",    64'(bus4.data_ID_o),    64'(m_id));
            chk("rnd_aux",   64'(bus4.data_aux_o),   64'(m_aux));
            if (rst) begin
                m_valid = 1'b0; m_ptr = 0; m_src = 0; m_add = '0; m_wdata = '0;
                m_aux = '0; m_wen = 1'b0; m_be = '0; m_id = '0;
            end else if (w >= 0) begin
                m_valid = 1'b1; m_src = w; m_ptr = (w + 1) % 4; m_add = t_add[w];
                m_wdata = t_wdata[w]; m_aux = t_aux[w]; m_wen = t_wen[w]; m_be = t_be[w]; m_id = t_id[w];
            end else if (bus4.data_gnt_i) begin
                m_valid = 1'b0;
            end
            tick();
            if (w >= 0) t_req[w] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
